imem_fetch_responder: RTL and testbench
=======================================

Name: imem_fetch_responder

Overview:
- Instruction-memory responder serving the processor's fetch port.
- The processor drives a PC-derived byte address. This block accepts one request at a time and returns the 32-bit instruction word after a programmable latency over a valid/ready handshake.
- Memory is preloaded through a word-indexed load port that the bench or boot logic drives.
- Also reports a completed-fetch counter for debug.

Parameters:
- DEPTH_LOG2, 8: log2 of the number of 32-bit words (default 256 words).
- LATENCY, 2: cycles from request acceptance to rsp_valid rising. Legal range 1..15.
- BASE_ADDR, 32'h0000_0000: byte address mapped to word 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  fetch request present.
- req_ready  output  1  block can accept a request.
- req_addr  input  32  fetch byte address (PC).
- rsp_valid  output  1  response word available.
- rsp_ready  input  1  processor consumes the response.
- rsp_data  output  32  instruction word.
- rsp_err  output  1  request was misaligned or out of range.
- ld_en  input  1  write enable for the load port.
- ld_addr  input  DEPTH_LOG2  word index for the load.
- ld_data  input  32  word to store.
- fetch_cnt  output  32  number of completed response handshakes.

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset (rst high at an edge) sets:
  - state = IDLE
  - rsp_valid = 0, rsp_data = 0, rsp_err = 0
  - fetch_cnt = 0
  - internal latency counter = 0
- Reset does not clear memory contents. A load coinciding with rst still writes.
- req_ready = (state == IDLE) && !rst. It is combinational from state; no request is accepted while rst is high.
- Acceptance happens at edge T when req_valid && req_ready. At that edge:
  - latch addr
  - err = (addr[1:0] != 0) || ((addr - BASE_ADDR) >> 2) >= 2^DEPTH_LOG2, with the subtraction done in 32-bit unsigned arithmetic, so addresses below BASE wrap high and flag err.
  - cnt = LATENCY - 1
  - next state: WAIT, or RESP directly when LATENCY == 1.
- WAIT: cnt decrements each edge. On the edge where cnt == 1 (or directly at acceptance for LATENCY == 1):
  - memory is read at the latched word index
  - rsp_data is registered
  - rsp_valid goes to 1, state goes to RESP.
- Timing: rsp_valid is first observed high in the cycle following edge T+LATENCY-1, i.e. exactly LATENCY cycles after the acceptance cycle.
- Error response: rsp_data = 32'h0000_0000 and rsp_err = 1. No memory access is performed.
- RESP: rsp_valid, rsp_data and rsp_err hold stable until rsp_ready is high at an edge. That edge:
  - clears rsp_valid and rsp_err
  - returns the FSM to IDLE
  - increments fetch_cnt, which wraps 32'hFFFF_FFFF -> 0.
- rsp_data keeps its last value after the handshake.
- Throughput is at most one fetch per LATENCY+1 cycles.
- Load port: ld_en writes mem[ld_addr] = ld_data at the edge, in any state.
- Load/read collision on the same word at the capture edge is read-before-write: the old word is returned and the new word is visible to later fetches.
- req_addr changes while not accepted, and req_valid deassertion during WAIT/RESP, are ignored.
- Reset mid-operation (WAIT or RESP) aborts the fetch: no response is produced and fetch_cnt is not incremented for it.
- No X on any output after the first reset edge.

Test Plan (DEPTH_LOG2=4, LATENCY=2, BASE_ADDR=0 unless stated):
- Load and fetch: load mem[0..3] = 32'h00000013, 32'h00100093, 32'h00208113, 32'h00310193; then fetch addr 0,4,8,12 with rsp_ready=1 -> data returned in order, each rsp_valid exactly 2 cycles after acceptance, fetch_cnt = 4.
- Error responses: fetch addr 32'h6 -> rsp_err=1, data 0. Fetch addr 32'h40 (word 16, out of range) -> rsp_err=1. fetch_cnt still increments for each.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> data/err stable, req_ready=0 throughout. Assert rsp_ready -> next cycle req_ready=1, rsp_valid=0.
- Load collision: accept fetch of word 2 (holding 32'hAAAA_AAAA) with a load of 32'h5555_5555 to word 2 at the capture edge -> response 32'hAAAA_AAAA; next fetch of word 2 returns 32'h5555_5555.
- Reset in WAIT: accept a fetch, assert rst for 1 cycle during WAIT -> rsp_valid never rises, fetch_cnt = 0, req_ready=0 during rst and 1 the cycle after. Memory contents preserved on a subsequent fetch.
- LATENCY=1 and BASE_ADDR=32'h1000 build: fetch 32'h1004 -> word 1, rsp_valid one cycle after acceptance. Fetch 32'h0FFC -> rsp_err=1.

Source files
------------

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder for the processor fetch port.
// Accepts one request at a time and returns the word after LATENCY cycles over valid/ready.
module imem_fetch_responder #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data,
    output logic [31:0]           fetch_cnt
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state, state_next;
    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  err_q;
    logic [CNT_W-1:0]      cnt;

    logic [31:0]           offset;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  req_err;
    logic                  accept;
    logic                  capture;
    logic                  handshake;
    logic [DEPTH_LOG2-1:0] cap_idx;
    logic                  cap_err;
    logic [31:0]           cap_data;

    // Addresses below BASE_ADDR wrap high in the unsigned subtraction and fail the range test.
    assign offset  = req_addr - BASE_ADDR;
    assign req_idx = offset[DEPTH_LOG2+1:2];
    assign req_err = (req_addr[1:0] != 2'b00) || ((offset >> (DEPTH_LOG2 + 2)) != 32'd0);

    assign req_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        handshake  = 1'b0;
        cap_idx    = idx_q;
        cap_err    = err_q;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        capture    = 1'b1;
                        cap_idx    = req_idx;
                        cap_err    = req_err;
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    handshake  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        cap_data = cap_err ? 32'h0000_0000 : mem[cap_idx];
    end

    // Registered datapath; the memory read uses the pre-edge contents, so a colliding load is read-before-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0000_0000;
            rsp_err   <= 1'b0;
            fetch_cnt <= 32'h0000_0000;
            cnt       <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                idx_q <= req_idx;
                err_q <= req_err;
                cnt   <= CNT_INIT;
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (capture) begin
                rsp_valid <= 1'b1;
                rsp_data  <= cap_data;
                rsp_err   <= cap_err;
            end else if (handshake) begin
                rsp_valid <= 1'b0;
                rsp_err   <= 1'b0;
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

    // Memory contents survive reset; loads are accepted in every state.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboard bench for imem_fetch_responder: a LATENCY=2/BASE=0 instance and a LATENCY=1/BASE=0x1000 instance.
module tb_imem_fetch_responder;

    localparam int unsigned DL = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          req_valid [2];
    logic          req_ready [2];
    logic [31:0]   req_addr  [2];
    logic          rsp_valid [2];
    logic          rsp_ready [2];
    logic [31:0]   rsp_data  [2];
    logic          rsp_err   [2];
    logic          ld_en     [2];
    logic [DL-1:0] ld_addr   [2];
    logic [31:0]   ld_data   [2];
    logic [31:0]   fetch_cnt [2];

    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    imem_fetch_responder #(.DEPTH_LOG2(DL), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .rsp_err(rsp_err[0]), .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]),
        .fetch_cnt(fetch_cnt[0])
    );

    imem_fetch_responder #(.DEPTH_LOG2(DL), .LATENCY(1), .BASE_ADDR(32'h0000_1000)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .rsp_err(rsp_err[1]), .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]),
        .fetch_cnt(fetch_cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic load(input int d, input logic [DL-1:0] idx, input logic [31:0] data);
        @(negedge clk);
        ld_en[d]   = 1'b1;
        ld_addr[d] = idx;
        ld_data[d] = data;
        @(negedge clk);
        ld_en[d]   = 1'b0;
    endtask

    // One fetch: push the expectation, time the response, pop and compare, then hold and release.
    task automatic fetch(input int d, input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic exp_err, input int lat, input int hold,
                         input logic coll, input logic [31:0] coll_data);
        exp_t e;
        int   n;
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_addr[d]  = addr;
        sb.push_back('{data: exp_data, err: exp_err});
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_addr[d]  = 32'hDEAD_BEEF;
        if (coll) begin
            ld_en[d]   = 1'b1;
            ld_addr[d] = addr[DL+1:2];
            ld_data[d] = coll_data;
        end
        n = 1;
        while (!rsp_valid[d] && n < 32) begin
            @(negedge clk);
            ld_en[d] = 1'b0;
            n++;
        end
        ld_en[d] = 1'b0;
        check("latency", 32'(n), 32'(lat));
        if (rsp_valid[d]) begin
            if (sb.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_data", rsp_data[d], e.data);
                check("rsp_err", 32'(rsp_err[d]), 32'(e.err));
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid[d]), 32'd1);
            check("hold_data", rsp_data[d], exp_data);
            check("hold_err", 32'(rsp_err[d]), 32'(exp_err));
            check("hold_req_ready", 32'(req_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        check("post_valid", 32'(rsp_valid[d]), 32'd0);
        check("post_err", 32'(rsp_err[d]), 32'd0);
        check("post_req_ready", 32'(req_ready[d]), 32'd1);
        check("post_data_kept", rsp_data[d], exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_addr[d]  = 32'h0;
            rsp_ready[d] = 1'b0;
            ld_en[d]     = 1'b0;
            ld_addr[d]   = '0;
            ld_data[d]   = 32'h0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_req_ready", 32'(req_ready[d]), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            check("rst_rsp_data", rsp_data[d], 32'd0);
            check("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
            check("rst_fetch_cnt", fetch_cnt[d], 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("req_ready_after_rst", 32'(req_ready[0]), 32'd1);

        // Load and fetch in order
        load(0, 4'd0, 32'h0000_0013);
        load(0, 4'd1, 32'h0010_0093);
        load(0, 4'd2, 32'h0020_8113);
        load(0, 4'd3, 32'h0031_0193);
        fetch(0, 32'h0, 32'h0000_0013, 1'b0, 2, 0, 1'b0, 32'h0);
        fetch(0, 32'h4, 32'h0010_0093, 1'b0, 2, 0, 1'b0, 32'h0);
        fetch(0, 32'h8, 32'h0020_8113, 1'b0, 2, 0, 1'b0, 32'h0);
        fetch(0, 32'hC, 32'h0031_0193, 1'b0, 2, 0, 1'b0, 32'h0);
        check("fetch_cnt_4", fetch_cnt[0], 32'd4);

        // Misaligned and out-of-range
        fetch(0, 32'h6, 32'h0, 1'b1, 2, 0, 1'b0, 32'h0);
        fetch(0, 32'h40, 32'h0, 1'b1, 2, 0, 1'b0, 32'h0);
        check("fetch_cnt_6", fetch_cnt[0], 32'd6);

        // Backpressure
        fetch(0, 32'hC, 32'h0031_0193, 1'b0, 2, 5, 1'b0, 32'h0);
        check("fetch_cnt_7", fetch_cnt[0], 32'd7);

        // Load colliding with the capture edge
        load(0, 4'd2, 32'hAAAA_AAAA);
        fetch(0, 32'h8, 32'hAAAA_AAAA, 1'b0, 2, 0, 1'b1, 32'h5555_5555);
        fetch(0, 32'h8, 32'h5555_5555, 1'b0, 2, 0, 1'b0, 32'h0);
        check("fetch_cnt_9", fetch_cnt[0], 32'd9);

        // Reset while waiting
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h4;
        @(negedge clk);
        req_valid[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rstw_req_ready", 32'(req_ready[0]), 32'd0);
        check("rstw_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("rstw_rsp_data", rsp_data[0], 32'd0);
        check("rstw_fetch_cnt", fetch_cnt[0], 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rstw_req_ready_after", 32'(req_ready[0]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstw_no_rsp", 32'(rsp_valid[0]), 32'd0);
        end
        check("rstw_fetch_cnt_idle", fetch_cnt[0], 32'd0);
        fetch(0, 32'h4, 32'h0010_0093, 1'b0, 2, 0, 1'b0, 32'h0);
        check("fetch_cnt_after_rst", fetch_cnt[0], 32'd1);

        // LATENCY=1, BASE_ADDR=0x1000 instance
        load(1, 4'd1, 32'h1234_5678);
        fetch(1, 32'h0000_1004, 32'h1234_5678, 1'b0, 1, 0, 1'b0, 32'h0);
        fetch(1, 32'h0000_0FFC, 32'h0, 1'b1, 1, 0, 1'b0, 32'h0);
        fetch(1, 32'h0000_1040, 32'h0, 1'b1, 1, 2, 1'b0, 32'h0);
        check("b_fetch_cnt", fetch_cnt[1], 32'd3);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
